// File: rtl/line_drawer.sv
// -----------------------------------------------------------------------------
// line_drawer
//   Bresenham line-drawing engine. Takes a line request from the Avalon slave
//   controller and walks it one pixel per clock into the VGA adapter's plot
//   interface. Handles every octant: steep lines, reversed endpoints and
//   negative slope.
//
//   Optional feature macro: LINE_DRAWER_CLIP_EN
//     defined   : pixels outside SCREEN_W x SCREEN_H are walked but not plotted
//     undefined : every DRAW pixel is plotted
//
//   Handshake: start is a level request. It is sampled only in IDLE. Once the
//   line is finished, done stays high until start is seen low, after which the
//   engine returns to IDLE (4-phase). Changes on start or on the coordinate
//   inputs while a line is in flight are ignored.
//
//   Ports
//     clk        in   system clock, rising edge
//     reset      in   asynchronous active-low reset
//     start      in   line request (level)
//     x0/y0      in   start point (9-bit x, 8-bit y)
//     x1/y1      in   end point
//     colour     in   pixel colour
//     done       out  line complete (DONE state)
//     vga_x/y    out  pixel coordinate
//     vga_colour out  pixel colour
//     vga_plot   out  pixel write strobe, one pixel per high cycle
//
//   The FSM state is held in state_q (type state_t) for hierarchical probing.
// -----------------------------------------------------------------------------
module line_drawer #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] x0,
    input  logic [7:0] y0,
    input  logic [8:0] x1,
    input  logic [7:0] y1,
    input  logic [2:0] colour,
    output logic       done,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q;

    // Request latched in IDLE
    logic [8:0] lx0_q, lx1_q;
    logic [7:0] ly0_q, ly1_q;
    logic [2:0] colour_q;

    // Walk registers (coordinates in the possibly swapped frame)
    logic              steep_q;
    logic              ystep_neg_q;
    logic [8:0]        x_q, y_q, xb_q, dx_q, dy_q;
    logic signed [10:0] err_q;

    // INIT-time setup computed from the latched request
    logic [8:0]        adx, ady, ax, ay, bx, by;
    logic              steep_d, ystep_neg_d;
    logic [8:0]        xa_d, ya_d, xb_d, yb_d, dx_d, dy_d;
    logic signed [10:0] err_init_d;

    // Next-step values during DRAW
    logic signed [10:0] err_sum;
    logic signed [10:0] err_step_d;
    logic [8:0]        x_step_d, y_step_d;

    // Pixel to present on the next cycle
    logic [8:0]        pix_x_d;
    logic [7:0]        pix_y_d;
    logic              plot_d;

    always_comb begin
        adx = (lx1_q >= lx0_q) ? (lx1_q - lx0_q) : (lx0_q - lx1_q);
        ady = (ly1_q >= ly0_q) ? {1'b0, ly1_q - ly0_q} : {1'b0, ly0_q - ly1_q};
        steep_d = (ady > adx);

        // Steep lines are walked along y, so exchange the axes
        ax = steep_d ? {1'b0, ly0_q} : lx0_q;
        ay = steep_d ? lx0_q         : {1'b0, ly0_q};
        bx = steep_d ? {1'b0, ly1_q} : lx1_q;
        by = steep_d ? lx1_q         : {1'b0, ly1_q};

        // Always walk left to right
        if (ax > bx) begin
            xa_d = bx; ya_d = by; xb_d = ax; yb_d = ay;
        end else begin
            xa_d = ax; ya_d = ay; xb_d = bx; yb_d = by;
        end

        dx_d        = xb_d - xa_d;
        dy_d        = (ya_d < yb_d) ? (yb_d - ya_d) : (ya_d - yb_d);
        ystep_neg_d = !(ya_d < yb_d);
        err_init_d  = -$signed({2'b00, dx_d >> 1});
    end

    always_comb begin
        err_sum    = err_q + $signed({2'b00, dy_q});
        err_step_d = err_sum;
        y_step_d   = y_q;
        if (!err_sum[10]) begin
            y_step_d   = ystep_neg_q ? (y_q - 9'd1) : (y_q + 9'd1);
            err_step_d = err_sum - $signed({2'b00, dx_q});
        end
        x_step_d = x_q + 9'd1;
    end

    // Map the walk frame back to screen coordinates
    always_comb begin
        if (state_q == S_INIT) begin
            pix_x_d = steep_d ? ya_d      : xa_d;
            pix_y_d = steep_d ? xa_d[7:0] : ya_d[7:0];
        end else begin
            pix_x_d = steep_q ? y_step_d      : x_step_d;
            pix_y_d = steep_q ? x_step_d[7:0] : y_step_d[7:0];
        end
`ifdef LINE_DRAWER_CLIP_EN
        plot_d = (pix_x_d < 9'(SCREEN_W)) && ({1'b0, pix_y_d} < 9'(SCREEN_H));
`else
        plot_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lx0_q       <= '0;
            lx1_q       <= '0;
            ly0_q       <= '0;
            ly1_q       <= '0;
            colour_q    <= '0;
            steep_q     <= 1'b0;
            ystep_neg_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            xb_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            done        <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    vga_plot <= 1'b0;
                    done     <= 1'b0;
                    if (start) begin
                        lx0_q    <= x0;
                        ly0_q    <= y0;
                        lx1_q    <= x1;
                        ly1_q    <= y1;
                        colour_q <= colour;
                        state_q  <= S_INIT;
                    end
                end
                S_INIT: begin
                    steep_q     <= steep_d;
                    ystep_neg_q <= ystep_neg_d;
                    x_q         <= xa_d;
                    y_q         <= ya_d;
                    xb_q        <= xb_d;
                    dx_q        <= dx_d;
                    dy_q        <= dy_d;
                    err_q       <= err_init_d;
                    // First pixel is registered here so it appears on the
                    // first DRAW cycle
                    vga_x       <= pix_x_d;
                    vga_y       <= pix_y_d;
                    vga_colour  <= colour_q;
                    vga_plot    <= plot_d;
                    state_q     <= S_DRAW;
                end
                S_DRAW: begin
                    if (x_q == xb_q) begin
                        vga_plot <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        x_q      <= x_step_d;
                        y_q      <= y_step_d;
                        err_q    <= err_step_d;
                        vga_x    <= pix_x_d;
                        vga_y    <= pix_y_d;
                        vga_plot <= plot_d;
                    end
                end
                S_DONE: begin
                    vga_plot <= 1'b0;
                    if (!start) begin
                        done    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_drawer.sv
// -----------------------------------------------------------------------------
// tb_line_drawer
//   Self-checking bench for line_drawer. A reference model computes each
//   line's pixel list with integer arithmetic into exp_q; the monitor checks
//   plot timing, pixel order, colour and the done handshake cycle by cycle.
// -----------------------------------------------------------------------------
module tb_line_drawer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] x0, x1;
    logic [7:0] y0, y1;
    logic [2:0] colour;
    logic       done;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int n_checks;
    int n_fail;
    int exp_dx;
    logic [19:0] exp_q[$];

    line_drawer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .colour     (colour),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic build_model(input int px0, input int py0, input int px1,
                               input int py1, input logic [2:0] col);
        int ax, ay, bx, by, t, dx, dy, err, ystep, x, y, ox, oy;
        bit steep;
        exp_q.delete();
        steep = iabs(py1 - py0) > iabs(px1 - px0);
        if (steep) begin
            ax = py0; ay = px0; bx = py1; by = px1;
        end else begin
            ax = px0; ay = py0; bx = px1; by = py1;
        end
        if (ax > bx) begin
            t = ax; ax = bx; bx = t;
            t = ay; ay = by; by = t;
        end
        dx    = bx - ax;
        dy    = iabs(by - ay);
        err   = -(dx / 2);
        ystep = (ay < by) ? 1 : -1;
        y     = ay;
        for (x = ax; x <= bx; x++) begin
            ox = steep ? (y & 511) : x;
            oy = steep ? (x & 255) : (y & 255);
            exp_q.push_back({9'(ox), 8'(oy), col});
            err += dy;
            if (err >= 0) begin
                y   += ystep;
                err -= dx;
            end
        end
        exp_dx = dx;
    endtask

    function automatic bit exp_visible(input logic [19:0] p);
`ifdef LINE_DRAWER_CLIP_EN
        return (p[19:11] < 9'd320) && (p[10:3] < 8'd240);
`else
        return (p[19:11] == p[19:11]) || 1'b1;
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic drive_line(input int px0, input int py0, input int px1,
                              input int py1, input logic [2:0] col);
        x0     = 9'(px0);
        y0     = 8'(py0);
        x1     = 9'(px1);
        y1     = 8'(py1);
        colour = col;
        start  = 1'b1;
        build_model(px0, py0, px1, py1, col);
    endtask

    // Waits for the sampling edge, then checks every cycle until done and
    // through the handshake release.
    task automatic check_line(input string name, input bit drop_early,
                              input bit scramble);
        logic [19:0] p;
        bit exp_plot, exp_done, in_draw;
        @(posedge clk);
        for (int k = 1; k <= exp_dx + 3; k++) begin
            @(negedge clk);
            if (k == 1 && scramble) begin
                x0 = 9'($urandom_range(0, 511));
                y0 = 8'($urandom_range(0, 255));
                x1 = 9'($urandom_range(0, 511));
                y1 = 8'($urandom_range(0, 255));
                colour = 3'($urandom_range(0, 7));
            end
            if (k == 1 && drop_early) start = 1'b0;
            in_draw  = (k >= 2) && (k <= exp_dx + 2);
            exp_done = (k == exp_dx + 3);
            p        = '0;
            exp_plot = 1'b0;
            if (in_draw) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s model_queue_empty k=%0d", name, k);
                end else begin
                    p        = exp_q.pop_front();
                    exp_plot = exp_visible(p);
                end
            end
            n_checks++;
            if (vga_plot !== exp_plot) begin
                n_fail++;
                $display("FAIL %s plot k=%0d got=%b exp=%b", name, k, vga_plot, exp_plot);
            end
            if (exp_plot) begin
                n_checks++;
                if ({vga_x, vga_y, vga_colour} !== p) begin
                    n_fail++;
                    $display("FAIL %s pixel k=%0d got=(%0d,%0d,c%0d) exp=(%0d,%0d,c%0d)",
                             name, k, vga_x, vga_y, vga_colour, p[19:11], p[10:3], p[2:0]);
                end
            end
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL %s done k=%0d got=%b exp=%b", name, k, done, exp_done);
            end
        end
        if (!drop_early) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b1 || vga_plot !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_hold got done=%b plot=%b exp done=1 plot=0",
                         name, done, vga_plot);
            end
            start = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || vga_plot !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_release got done=%b plot=%b exp done=0 plot=0",
                     name, done, vga_plot);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done, vga_x, vga_y, vga_colour, vga_plot} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {done, vga_x, vga_y, vga_colour, vga_plot});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (vga_plot !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet got plot=%b done=%b exp 0 0", vga_plot, done);
        end
    endtask

    task automatic test_directed;
        drive_line(10, 20, 14, 20, 3'd5);  check_line("horizontal", 1'b0, 1'b0);
        drive_line(14, 20, 10, 20, 3'd5);  check_line("reversed", 1'b0, 1'b0);
        drive_line(0, 0, 2, 5, 3'd2);      check_line("steep", 1'b0, 1'b0);
        drive_line(7, 7, 7, 7, 3'd7);      check_line("point", 1'b1, 1'b0);
        drive_line(0, 3, 3, 0, 3'd1);      check_line("neg_slope", 1'b0, 1'b0);
        drive_line(318, 10, 322, 10, 3'd4); check_line("clip_edge", 1'b0, 1'b0);
        drive_line(5, 200, 2, 3, 3'd6);    check_line("steep_reversed", 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_line;
        drive_line(0, 0, 100, 0, 3'd3);
        @(posedge clk);
        repeat (4) @(negedge clk);      // cycle holding the 3rd plot
        n_checks++;
        if (vga_plot !== 1'b1 || vga_x !== 9'd2) begin
            n_fail++;
            $display("FAIL rst_mid_third_plot got plot=%b x=%0d exp plot=1 x=2", vga_plot, vga_x);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({done, vga_x, vga_y, vga_colour, vga_plot} !== 22'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async got=%h exp=0",
                     {done, vga_x, vga_y, vga_colour, vga_plot});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (vga_plot !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_held plot got=%b exp=0", vga_plot);
            end
        end
        reset = 1'b1;                    // start still high: redraw
        build_model(0, 0, 100, 0, 3'd3);
        check_line("rst_redraw", 1'b0, 1'b0);
    endtask

    task automatic test_random;
        int a, b, c, d;
        bit full;
        for (int i = 0; i < 14; i++) begin
            full = ($urandom_range(0, 3) == 0);
            a = full ? $urandom_range(0, 511) : $urandom_range(0, 319);
            b = full ? $urandom_range(0, 255) : $urandom_range(0, 239);
            c = full ? $urandom_range(0, 511) : $urandom_range(0, 319);
            d = full ? $urandom_range(0, 255) : $urandom_range(0, 239);
            if (i % 4 == 0) c = a + $urandom_range(0, 1) - ((a == 511) ? 1 : 0);
            drive_line(a, b, c, d, 3'($urandom_range(0, 7)));
            check_line($sformatf("random%0d", i), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back;
        drive_line(1, 1, 4, 2, 3'd3);
        check_line("b2b_first", 1'b1, 1'b0);
        drive_line(50, 60, 45, 70, 3'd6);
        check_line("b2b_second", 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_reset_mid_line();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_drawer.md
Name: line_drawer

Overview:
Bresenham line-drawing engine directly downstream of the Avalon slave controller for the line-draw peripheral.
- Consumes the controller's start/x0/y0/x1/y1/colour and returns done.
- Emits one pixel per clock to the VGA adapter's plot interface.
- Handles all octants: steep lines, reversed endpoints, negative slope.

Parameters:
SCREEN_W, 320, visible width in pixels; used only by the clip option.
SCREEN_H, 240, visible height in pixels; used only by the clip option.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  level request from the controller; held high until done is seen.
x0  input  9  start x.
y0  input  8  start y.
x1  input  9  end x.
y1  input  8  end y.
colour  input  3  pixel colour.
done  output  1  line complete; high in DONE state.
vga_x  output  9  pixel x.
vga_y  output  8  pixel y.
vga_colour  output  3  pixel colour.
vga_plot  output  1  pixel write strobe, one pixel per high cycle.

Behaviour:
- Reset (reset=0, async): state=IDLE; done, vga_plot, vga_x, vga_y and vga_colour are all 0; internal registers are 0.
- States: IDLE, INIT, DRAW, DONE.
- IDLE: when start=1, latch x0, y0, x1, y1 and colour, then go to INIT. start=0 holds IDLE.
- INIT (1 cycle):
  - steep = |y1-y0| > |x1-x0|. If steep, swap x and y of both endpoints.
  - If the (swapped) xa > xb, swap endpoints.
  - dx = xb-xa; dy = |yb-ya|; err = -(dx>>1); ystep = +1 if ya<yb, else -1.
  - Go to DRAW.
- DRAW, once per cycle:
  - vga_plot=1.
  - Output pixel: vga_x/vga_y = (y,x) if steep, else (x,y). vga_colour = latched colour.
  - err += dy; if err >= 0 then y += ystep and err -= dx. x += 1.
  - After plotting x == xb, go to DONE.
  - Pixel count is exactly dx+1.
- Arithmetic widths:
  - Coordinates are internally 9-bit unsigned (y zero-extended).
  - dx and dy are 9-bit.
  - err is 11-bit signed; no overflow for any 9-bit operands.
- DONE:
  - done=1, vga_plot=0.
  - Stay while start=1; go to IDLE when start=0 (4-phase handshake).
  - If start is already 0 on entry, done is high for exactly one cycle.
- vga_plot is 0 in IDLE, INIT and DONE.
- Latency: start sampled high at edge N → first plot in cycle N+2 → last plot in cycle N+2+dx → done high from cycle N+3+dx.
- start dropping during INIT/DRAW is ignored; the line completes.
- Input changes after the IDLE latch are ignored.
- Degenerate line (x0=x1, y0=y1): one plot, then DONE.
- Reset mid-line: immediate IDLE, all outputs 0; no further plots.

Optional Feature:
LINE_DRAWER_CLIP_EN
- Defined: in DRAW, vga_plot is forced to 0 for any pixel with vga_x >= SCREEN_W or vga_y >= SCREEN_H. The state machine still walks the full dx+1 steps, so cycle timing and done are unchanged.
- Not defined: every DRAW pixel is plotted regardless of coordinates.

Test Plan:
- Horizontal: (10,20)→(14,20), colour=5 → plots (10..14,20), 5 plots with vga_colour=5; done in cycle N+7; done held until start=0, then IDLE.
- Reversed: (14,20)→(10,20) → same 5 pixels, emitted x=10..14; dx=4.
- Steep: (0,0)→(2,5) → plots in order (0,0),(1,1),(1,2),(1,3),(2,4),(2,5); exactly 6 plot cycles.
- Point and negative slope:
  - (7,7)→(7,7) → single plot (7,7), then done.
  - (0,3)→(3,0) → (0,3),(1,2),(2,1),(3,0).
- Reset: assert reset=0 during the 3rd plot of (0,0)→(100,0) → outputs 0 asynchronously, no further plots. After release with start=1, the line redraws from (0,0).
- Clip:
  - (318,10)→(322,10) with LINE_DRAWER_CLIP_EN → plots only x=318,319; done at the same cycle as the unclipped case.
  - Same line without the macro → 5 plots.
